// File: rtl/rename_regfile_pkg.sv
// Shared defaults for the rename register file and its read ports.
package rename_regfile_pkg;

  localparam int unsigned REG_NUM_DEF   = 32;
  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned ROB_W_DEF     = 4;
  localparam int unsigned RD_PORTS_DEF  = 2;
  localparam int unsigned CMT_PORTS_DEF = 2;
  localparam int unsigned RW_DEF        = $clog2(REG_NUM_DEF);

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: stored state of the indexed register,
// overridden by a same-cycle commit that retires its current producer.
module regfile_read_port
  import rename_regfile_pkg::*;
#(
  parameter int unsigned RW        = RW_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ROB_W     = ROB_W_DEF,
  parameter int unsigned CMT_PORTS = CMT_PORTS_DEF
) (
  input  logic [RW-1:0]             rd_idx,
  input  logic                      st_busy,
  input  logic [DATA_W-1:0]         st_data,
  input  logic [ROB_W-1:0]          st_tag,
  input  logic [CMT_PORTS-1:0]      cmt_en,
  input  logic [CMT_PORTS*RW-1:0]   cmt_rd,
  input  logic [CMT_PORTS*DATA_W-1:0] cmt_data,
  input  logic [CMT_PORTS*ROB_W-1:0] cmt_tag,
  output logic                      rd_busy,
  output logic [DATA_W-1:0]         rd_data,
  output logic [ROB_W-1:0]          rd_tag
);

  // Bypass select: ascending scan so the youngest matching commit port wins.
  always_comb begin
    rd_busy = st_busy;
    rd_data = st_data;
    rd_tag  = st_busy ? st_tag : '0;
    for (int unsigned c = 0; c < CMT_PORTS; c++) begin
      if (cmt_en[c] && st_busy &&
          (cmt_rd[c*RW +: RW] == rd_idx) &&
          (cmt_tag[c*ROB_W +: ROB_W] == st_tag)) begin
        rd_busy = 1'b0;
        rd_data = cmt_data[c*DATA_W +: DATA_W];
        rd_tag  = '0;
      end
    end
  end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with rename (busy/tag) tracking, commit
// write-back, rollback flush and bypassed combinational read ports.
module rename_regfile
  import rename_regfile_pkg::*;
#(
  parameter int unsigned REG_NUM   = REG_NUM_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ROB_W     = ROB_W_DEF,
  parameter int unsigned RD_PORTS  = RD_PORTS_DEF,
  parameter int unsigned CMT_PORTS = CMT_PORTS_DEF,
  localparam int unsigned RW       = $clog2(REG_NUM)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic [RD_PORTS*RW-1:0]      rd_idx,
  output logic [RD_PORTS-1:0]         rd_busy,
  output logic [RD_PORTS*DATA_W-1:0]  rd_data,
  output logic [RD_PORTS*ROB_W-1:0]   rd_tag,
  input  logic                        ren_en,
  input  logic [RW-1:0]               ren_rd,
  input  logic [ROB_W-1:0]            ren_tag,
  input  logic [CMT_PORTS-1:0]        cmt_en,
  input  logic [CMT_PORTS*RW-1:0]     cmt_rd,
  input  logic [CMT_PORTS*DATA_W-1:0] cmt_data,
  input  logic [CMT_PORTS*ROB_W-1:0]  cmt_tag,
  input  logic                        rollback,
  output logic [RW:0]                 busy_cnt
);

  logic [DATA_W-1:0]  data_q [REG_NUM];
  logic [DATA_W-1:0]  data_d [REG_NUM];
  logic [ROB_W-1:0]   tag_q  [REG_NUM];
  logic [ROB_W-1:0]   tag_d  [REG_NUM];
  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;
  logic [REG_NUM-1:0] cmt_clr;
  logic [RW:0]        busy_cnt_q;
  logic [RW:0]        busy_cnt_d;

  // Next-state: commits write data and retire matching producers, then
  // rollback or rename overrides busy/tag; register 0 is pinned to zero.
  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    busy_d  = busy_q;
    cmt_clr = '0;
    if (rdy) begin
      // Ascending order leaves the youngest port's data in place; the
      // busy-clear test reads stored state so either port may retire.
      for (int unsigned c = 0; c < CMT_PORTS; c++) begin
        if (cmt_en[c]) begin
          data_d[cmt_rd[c*RW +: RW]] = cmt_data[c*DATA_W +: DATA_W];
          if (busy_q[cmt_rd[c*RW +: RW]] &&
              (tag_q[cmt_rd[c*RW +: RW]] == cmt_tag[c*ROB_W +: ROB_W])) begin
            cmt_clr[cmt_rd[c*RW +: RW]] = 1'b1;
          end
        end
      end
      busy_d = busy_q & ~cmt_clr;
      for (int unsigned r = 0; r < REG_NUM; r++) begin
        if (cmt_clr[r]) begin
          tag_d[r] = '0;
        end
      end
      if (rollback) begin
        busy_d = '0;
        for (int unsigned r = 0; r < REG_NUM; r++) begin
          tag_d[r] = '0;
        end
      end else if (ren_en && (ren_rd != '0)) begin
        busy_d[ren_rd] = 1'b1;
        tag_d[ren_rd]  = ren_tag;
      end
    end
    data_d[0] = '0;
    tag_d[0]  = '0;
    busy_d[0] = 1'b0;
  end

  // Busy count follows the next-state busy vector so it updates with it.
  always_comb begin
    busy_cnt_d = '0;
    for (int unsigned r = 0; r < REG_NUM; r++) begin
      busy_cnt_d = busy_cnt_d + (RW+1)'(busy_d[r]);
    end
  end

  // State registers; reset dominates rdy, rollback, rename and commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < REG_NUM; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      data_q     <= data_d;
      tag_q      <= tag_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [RW-1:0] idx;
    assign idx = rd_idx[p*RW +: RW];

    regfile_read_port #(
      .RW        (RW),
      .DATA_W    (DATA_W),
      .ROB_W     (ROB_W),
      .CMT_PORTS (CMT_PORTS)
    ) u_rd (
      .rd_idx   (idx),
      .st_busy  (busy_q[idx]),
      .st_data  (data_q[idx]),
      .st_tag   (tag_q[idx]),
      .cmt_en   (cmt_en),
      .cmt_rd   (cmt_rd),
      .cmt_data (cmt_data),
      .cmt_tag  (cmt_tag),
      .rd_busy  (rd_busy[p]),
      .rd_data  (rd_data[p*DATA_W +: DATA_W]),
      .rd_tag   (rd_tag[p*ROB_W +: ROB_W])
    );
  end

endmodule

// File: doc/rename_regfile.md
RENAME_REGFILE -- requirements
Module: rename_regfile

Interface
REQ-001 SHALL have parameter REG_NUM, default 32, architectural register count (power of two, index width RW=log2(REG_NUM)).
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL have parameter ROB_W, default 4, ROB tag width.
REQ-004 SHALL have parameter RD_PORTS, default 2, number of read ports; CMT_PORTS, default 2, number of commit ports (port index order = program order, higher = younger).
REQ-005 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous, active-high; rdy in 1 global enable.
REQ-006 SHALL have ports: rd_idx in RD_PORTS*RW read register indices; rd_busy out RD_PORTS busy flags; rd_data out RD_PORTS*DATA_W values; rd_tag out RD_PORTS*ROB_W producing ROB tags.
REQ-007 SHALL have ports: ren_en in 1 rename strobe; ren_rd in RW destination; ren_tag in ROB_W new producer tag.
REQ-008 SHALL have ports: cmt_en in CMT_PORTS strobes; cmt_rd in CMT_PORTS*RW; cmt_data in CMT_PORTS*DATA_W; cmt_tag in CMT_PORTS*ROB_W.
REQ-009 SHALL have ports: rollback in 1 flush; busy_cnt out RW+1 count of busy registers.

Function
REQ-010 Per register SHALL hold data, busy bit, tag; register 0 SHALL read busy=0, data=0, tag=0 and ignore all writes/renames.
REQ-011 Read ports SHALL be combinational, zero latency, all ports independent.
REQ-012 Read bypass: if any enabled commit port c has cmt_rd==rd_idx and cmt_tag==stored tag and register busy, read SHALL return busy=0, data=cmt_data[c], tag=0; otherwise stored busy/data/tag (tag=0 when not busy).
REQ-013 Multiple bypass hits on one read SHALL select the highest-index commit port.
REQ-014 Reads SHALL NOT see a same-cycle rename (pre-rename state returned).
REQ-015 Commit (rdy=1): cmt_en[c] SHALL write cmt_data into cmt_rd unconditionally; SHALL clear busy only if register busy and stored tag==cmt_tag.
REQ-016 Two commit ports to same rd in one cycle: higher index data SHALL win; busy cleared if either port's tag matches stored tag.
REQ-017 Rename (rdy=1, ren_en=1, rollback=0, ren_rd!=0): SHALL set busy=1, tag=ren_tag on next edge.
REQ-018 Rename and commit to same rd same cycle: data SHALL take commit value; busy/tag SHALL take rename values.
REQ-019 Rollback (rdy=1): SHALL clear every busy bit and tag to 0; ignore ren_en that cycle; commits same cycle SHALL still write data.
REQ-020 rdy=0: all state SHALL hold; reads SHALL still reflect stored state plus bypass.
REQ-021 busy_cnt SHALL be registered, equal to popcount of busy bits after the same edge (updated with them), range 0..REG_NUM-1.

Reset
REQ-022 On rst=1 at clk edge (regardless of rdy): all data, busy, tags SHALL be 0; busy_cnt=0; rst SHALL override rollback, rename, commit.
REQ-023 Reset mid-operation SHALL discard all pending renames; first post-reset reads SHALL return busy=0, data=0.

Structure
REQ-024 Shared package SHALL hold default REG_NUM, DATA_W, ROB_W, RD_PORTS, CMT_PORTS and derived RW.
REQ-025 Read-port bypass logic SHALL be one sub-module, regfile_read_port, instantiated RD_PORTS times via generate.
REQ-026 Storage and busy_cnt SHALL reside in rename_regfile; busy_cnt computed from next-state busy vector.

Verification
REQ-027 Reset, then read x5 on both ports -> busy=0, data=0, tag=0, busy_cnt=0.
REQ-028 Rename x5 tag 3; next cycle read x5 -> busy=1, tag=3, busy_cnt=1; commit x5 tag 3 data 0xAB same cycle as read -> read returns busy=0, data 0xAB; following cycle stored busy=0, busy_cnt=0.
REQ-029 Rename x7 tag 2 then x7 tag 6; commit x7 tag 2 data 0x11 -> x7 data=0x11, still busy, tag=6; commit tag 6 data 0x22 -> busy=0, data=0x22.
REQ-030 Same cycle: commit x4 tag 1 data 0x55 (busy tag 1) and rename x4 tag 9 -> next cycle busy=1, tag=9, data=0x55.
REQ-031 Commit ports 0 and 1 both x9 (data 0x1, 0x2) -> x9 data=0x2; rename x0 tag 5 -> x0 reads busy=0, data=0.
REQ-032 Rename x1,x2,x3 (busy_cnt=3), then rollback with rename x8 and commit x2 data 0x77 same cycle -> all busy=0, busy_cnt=0, x8 not busy, x2 data=0x77; rdy=0 cycle with rename -> no change.
